hs_updater: RTL and testbench

HS_UPDATER -- requirements
Module: hs_updater

---
 rtl/hs_updater.sv | 154 +++++++++++++++
 tb/tb_hs_updater.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_updater.sv
// High-score table updater. On a game_over pulse it reads the whole table
// into a shadow copy, finds where the new score belongs, and rewrites the
// entries from that slot downward. Lower entries shift down by one and the
// lowest entry is dropped. Address 0 holds the highest score.
module hs_updater #(
  parameter int unsigned NUM_ENTRIES = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        game_over,
  input  logic [31:0] new_score,
  input  logic [31:0] ram_data_out,
  output logic [1:0]  ram_read_address,
  output logic [1:0]  ram_write_address,
  output logic [31:0] ram_data_in,
  output logic        ram_we,
  output logic        busy,
  output logic        done,
  output logic [1:0]  rank
);

  // Highest table index, last LOAD count value, and the "not placed" rank code.
  localparam logic [1:0] LastIdx   = 2'(NUM_ENTRIES - 1);
  localparam logic [2:0] LoadLast  = 3'(NUM_ENTRIES);
  localparam logic [1:0] NotPlaced = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCompare,
    StWrite,
    StDone
  } state_e;

  state_e      r_state, w_state_d;
  logic [31:0] r_score, w_score_d;
  logic [2:0]  r_cnt, w_cnt_d;
  logic [31:0] r_shadow [NUM_ENTRIES];
  logic [31:0] w_shadow_d [NUM_ENTRIES];
  logic [1:0]  r_rank, w_rank_d;
  logic [1:0]  r_widx, w_widx_d;

  logic [1:0]  w_rank_calc;
  logic [1:0]  w_cap_idx;
  logic [1:0]  w_prev_idx;

  // Slot the captured shadow word goes to: read data lags the address by one.
  assign w_cap_idx  = 2'(r_cnt - 3'd1);
  // Source of the shifted word; clamped so index 0 never wraps.
  assign w_prev_idx = (r_widx == 2'd0) ? 2'd0 : r_widx - 2'd1;

  // Lowest index whose stored score the new score strictly beats; ties lose.
  always_comb begin
    w_rank_calc = NotPlaced;
    for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
      if (r_score > r_shadow[i]) begin
        w_rank_calc = 2'(i);
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= StIdle;
      r_score <= 32'd0;
      r_cnt   <= 3'd0;
      r_rank  <= NotPlaced;
      r_widx  <= 2'd0;
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        r_shadow[i] <= 32'd0;
      end
    end else begin
      r_state  <= w_state_d;
      r_score  <= w_score_d;
      r_cnt    <= w_cnt_d;
      r_rank   <= w_rank_d;
      r_widx   <= w_widx_d;
      r_shadow <= w_shadow_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    w_state_d  = r_state;
    w_score_d  = r_score;
    w_cnt_d    = r_cnt;
    w_rank_d   = r_rank;
    w_widx_d   = r_widx;
    w_shadow_d = r_shadow;
    unique case (r_state)
      StIdle: begin
        if (game_over) begin
          w_score_d = new_score;
          w_cnt_d   = 3'd0;
          w_state_d = StLoad;
        end
      end
      StLoad: begin
        if (r_cnt != 3'd0) begin
          w_shadow_d[w_cap_idx] = ram_data_out;
        end
        if (r_cnt == LoadLast) begin
          w_state_d = StCompare;
        end else begin
          w_cnt_d = r_cnt + 3'd1;
        end
      end
      StCompare: begin
        w_rank_d = w_rank_calc;
        if (w_rank_calc == NotPlaced) begin
          w_state_d = StDone;
        end else begin
          w_widx_d  = w_rank_calc;
          w_state_d = StWrite;
        end
      end
      StWrite: begin
        if (r_widx == LastIdx) begin
          w_state_d = StDone;
        end else begin
          w_widx_d = r_widx + 2'd1;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Output decode; write strobes are cut by Reset so a reset mid-WRITE stops
  // the write landing on the same edge.
  always_comb begin
    ram_read_address  = 2'd0;
    ram_write_address = 2'd0;
    ram_data_in       = 32'd0;
    ram_we            = 1'b0;
    busy              = (r_state != StIdle);
    done              = (r_state == StDone);
    rank              = r_rank;
    if (r_state == StLoad && r_cnt < LoadLast) begin
      ram_read_address = r_cnt[1:0];
    end
    if (r_state == StWrite && !Reset) begin
      ram_we            = 1'b1;
      ram_write_address = r_widx;
      ram_data_in       = (r_widx == r_rank) ? r_score : r_shadow[w_prev_idx];
    end
  end

endmodule

// File: tb/tb_hs_updater.sv
// Bench for hs_updater: behavioural table RAM, a reference table model that
// pushes expected writes to a queue, and per-scenario tasks that compare.
module tb_hs_updater;

  logic        clk = 1'b0;
  logic        Reset;
  logic        game_over;
  logic [31:0] new_score;
  logic [31:0] ram_data_out;
  logic [1:0]  ram_read_address;
  logic [1:0]  ram_write_address;
  logic [31:0] ram_data_in;
  logic        ram_we;
  logic        busy;
  logic        done;
  logic [1:0]  rank;

  always #5 clk = ~clk;

  hs_updater #(.NUM_ENTRIES(3)) dut (
    .Clk              (clk),
    .Reset            (Reset),
    .game_over        (game_over),
    .new_score        (new_score),
    .ram_data_out     (ram_data_out),
    .ram_read_address (ram_read_address),
    .ram_write_address(ram_write_address),
    .ram_data_in      (ram_data_in),
    .ram_we           (ram_we),
    .busy             (busy),
    .done             (done),
    .rank             (rank)
  );

  // Table RAM: synchronous read and write; bench preload port has priority.
  logic [31:0] mem [3];
  logic        pre_we = 1'b0;
  logic [1:0]  pre_addr = 2'd0;
  logic [31:0] pre_data = 32'd0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_write_address] <= ram_data_in;
    ram_data_out <= mem[ram_read_address];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         obs_q[$];
  logic [31:0] ref_tab [3];
  int          n_vec = 0;
  int          n_err = 0;

  // Observations gathered by watch().
  int          done_cnt, done_cyc, load_cyc, bad_out, busy_gap;
  logic [7:0]  rd_seq;

  task automatic preload(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
    logic [31:0] v [3];
    v[0] = a0; v[1] = a1; v[2] = a2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_addr = 2'(i); pre_data = v[i];
      ref_tab[i] = v[i];
    end
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Reference model: compute rank, push the expected writes, update table.
  task automatic push_expected(input logic [31:0] s, output int r);
    logic [31:0] nt [3];
    r = 3;
    for (int i = 2; i >= 0; i--) if (s > ref_tab[i]) r = i;
    nt = ref_tab;
    for (int w = r; w < 3; w++) begin
      nt[w] = (w == r) ? s : ref_tab[w-1];
      exp_q.push_back({2'(w), nt[w]});
    end
    ref_tab = nt;
  endtask

  // Pulse game_over; returns on the first LOAD cycle's falling edge.
  task automatic submit(input logic [31:0] s);
    @(negedge clk);
    game_over = 1'b1; new_score = s;
    @(negedge clk);
    game_over = 1'b0;
    load_cyc = cyc;
  endtask

  // Collect DUT activity until two cycles after done, bounded by a budget.
  task automatic watch(input int inject_at, output bit timed_out);
    int k = 0;
    int post = -1;
    obs_q.delete();
    done_cnt = 0; done_cyc = -1; bad_out = 0; busy_gap = 0; rd_seq = 8'hff;
    timed_out = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (k < 4) rd_seq[2*k +: 2] = ram_read_address;
      k++;
      if (ram_we) obs_q.push_back({ram_write_address, ram_data_in});
      else if (ram_write_address != 2'd0 || ram_data_in != 32'd0) bad_out++;
      if (done) begin done_cnt++; done_cyc = cyc; if (post < 0) post = 0; end
      if (!busy && done_cnt == 0) busy_gap++;
      if (post >= 0) begin
        if (post == 2) begin timed_out = 1'b0; break; end
        post++;
      end
      if (n == inject_at) begin game_over = 1'b1; new_score = 32'd999; end
      else game_over = 1'b0;
      @(negedge clk);
    end
    game_over = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; game_over = 1'b1; new_score = 32'd1234;
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", ram_we); end
    n_vec++; if (rank !== 2'd3) begin n_err++; $display("FAIL reset_rank: got %0d want 3", rank); end
    n_vec++;
    if ({ram_read_address, ram_write_address, ram_data_in} !== 36'd0) begin
      n_err++;
      $display("FAIL reset_addr_data: got %h want 0",
               {ram_read_address, ram_write_address, ram_data_in});
    end
    Reset = 1'b0; game_over = 1'b0;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_placement();
    logic [31:0] scores [4];
    int r, exp_lat;
    bit to;
    wr_t e, o;
    scores[0] = 32'd400; scores[1] = 32'd50; scores[2] = 32'd600; scores[3] = 32'd300;
    for (int v = 0; v < 4; v++) begin
      preload(32'd500, 32'd300, 32'd100);
      exp_q.delete();
      push_expected(scores[v], r);
      submit(scores[v]);
      watch(-1, to);
      exp_lat = (r == 3) ? 5 : 5 + (3 - r);
      n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL timeout[%0d]: got %b want 0", v, to); end
      n_vec++; if (rank !== 2'(r)) begin n_err++; $display("FAIL rank[%0d]: got %0d want %0d", v, rank, r); end
      n_vec++;
      if (done_cyc - load_cyc !== exp_lat) begin
        n_err++; $display("FAIL latency[%0d]: got %0d want %0d", v, done_cyc - load_cyc, exp_lat);
      end
      n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL done_pulses[%0d]: got %0d want 1", v, done_cnt); end
      n_vec++; if (rd_seq !== 8'h24) begin n_err++; $display("FAIL read_seq[%0d]: got %h want 24", v, rd_seq); end
      n_vec++; if (bad_out !== 0) begin n_err++; $display("FAIL idle_outputs[%0d]: got %0d want 0", v, bad_out); end
      n_vec++; if (busy_gap !== 0) begin n_err++; $display("FAIL busy[%0d]: got %0d gaps want 0", v, busy_gap); end
      n_vec++;
      if (obs_q.size() !== exp_q.size()) begin
        n_err++; $display("FAIL write_count[%0d]: got %0d want %0d", v, obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_vec++;
        if (o !== e) begin
          n_err++; $display("FAIL write[%0d]: got a%0d=%0d want a%0d=%0d", v, o.addr, o.data, e.addr, e.data);
        end
      end
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (mem[i] !== ref_tab[i]) begin
          n_err++; $display("FAIL ram[%0d][%0d]: got %0d want %0d", v, i, mem[i], ref_tab[i]);
        end
      end
    end
  endtask

  task automatic test_ignore();
    int r;
    bit to;
    wr_t e, o;
    preload(32'd500, 32'd300, 32'd100);
    exp_q.delete();
    push_expected(32'd400, r);
    submit(32'd400);
    watch(1, to);
    n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL ign_timeout: got %b want 0", to); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL ign_done_pulses: got %0d want 1", done_cnt); end
    n_vec++; if (rank !== 2'(r)) begin n_err++; $display("FAIL ign_rank: got %0d want %0d", rank, r); end
    n_vec++;
    if (obs_q.size() !== exp_q.size()) begin
      n_err++; $display("FAIL ign_write_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++; $display("FAIL ign_write: got a%0d=%0d want a%0d=%0d", o.addr, o.data, e.addr, e.data);
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (mem[i] !== ref_tab[i]) begin
        n_err++; $display("FAIL ign_ram[%0d]: got %0d want %0d", i, mem[i], ref_tab[i]);
      end
    end
  endtask

  // Two submissions in a row on the table left by the previous test.
  task automatic test_back_to_back();
    logic [31:0] scores [2];
    int r;
    bit to;
    wr_t e, o;
    scores[0] = 32'd450; scores[1] = 32'd1000;
    for (int v = 0; v < 2; v++) begin
      exp_q.delete();
      push_expected(scores[v], r);
      submit(scores[v]);
      watch(-1, to);
      n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL b2b_timeout[%0d]: got %b want 0", v, to); end
      n_vec++; if (rank !== 2'(r)) begin n_err++; $display("FAIL b2b_rank[%0d]: got %0d want %0d", v, rank, r); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
        n_vec++;
        if (o !== e) begin
          n_err++; $display("FAIL b2b_write[%0d]: got a%0d=%0d want a%0d=%0d", v, o.addr, o.data, e.addr, e.data);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (mem[i] !== ref_tab[i]) begin
        n_err++; $display("FAIL b2b_ram[%0d]: got %0d want %0d", i, mem[i], ref_tab[i]);
      end
    end
  endtask

  // Reset on the second WRITE cycle: addr0 already written, addr1 must not be.
  task automatic test_reset_write();
    int nw = 0;
    bit hit = 1'b0;
    wr_t e, o;
    preload(32'd500, 32'd300, 32'd100);
    exp_q.delete();
    exp_q.push_back({2'd0, 32'd600});
    exp_q.push_back({2'd1, 32'd500});
    submit(32'd600);
    for (int n = 0; n < 20; n++) begin
      if (ram_we) begin
        nw++;
        e = exp_q.pop_front(); o = {ram_write_address, ram_data_in};
        n_vec++;
        if (o !== e) begin
          n_err++; $display("FAIL rw_write[%0d]: got a%0d=%0d want a%0d=%0d", nw, o.addr, o.data, e.addr, e.data);
        end
        if (nw == 2) begin
          Reset = 1'b1;
          #1;
          n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rw_we_gate: got %b want 0", ram_we); end
          hit = 1'b1;
          @(negedge clk);
          Reset = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL rw_timeout: got %b want 1", hit); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rw_busy: got %b want 0", busy); end
    n_vec++; if (rank !== 2'd3) begin n_err++; $display("FAIL rw_rank: got %0d want 3", rank); end
    n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rw_we: got %b want 0", ram_we); end
    ref_tab[0] = 32'd600; ref_tab[1] = 32'd300; ref_tab[2] = 32'd100;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (mem[i] !== ref_tab[i]) begin
        n_err++; $display("FAIL rw_ram[%0d]: got %0d want %0d", i, mem[i], ref_tab[i]);
      end
    end
  endtask

  initial begin
    Reset = 1'b1; game_over = 1'b0; new_score = 32'd0;
    test_reset();
    test_placement();
    test_ignore();
    test_back_to_back();
    test_reset_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
